dmem_mmio: RTL and testbench

DMEM_MMIO -- requirements
Module: dmem_mmio

---
 rtl/dmem_mmio_pkg.sv | 16 +
 rtl/dmem_mmio_tx_fifo.sv | 55 +++++
 rtl/dmem_mmio.sv | 109 ++++++++++
 tb/tb_dmem_mmio.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data memory / MMIO block:
// MMIO register offsets (Addr[3:2]) and STATUS bit positions.
package dmem_mmio_pkg;

    localparam logic [1:0] MMIO_GPIO   = 2'd0;
    localparam logic [1:0] MMIO_CYCLE  = 2'd1;
    localparam logic [1:0] MMIO_TXDATA = 2'd2;
    localparam logic [1:0] MMIO_STATUS = 2'd3;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 4;
    localparam int ST_CNT_W  = 4;

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte-wide TX FIFO with sticky overflow flag.
// A push into a full FIFO is taken only when a pop frees a slot that same cycle.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          clr_ovf,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    // Pointer, occupancy and overflow bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count + CW'(do_push) - CW'(do_pop);
            overflow <= (overflow & ~clr_ovf) | drop;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data RAM plus MMIO block (GPIO, cycle counter, TX FIFO, STATUS).
// Reads are combinational from Addr; writes commit on the rising edge.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [7:0]  GpioOut,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          is_io;
    logic [1:0]    io_sel;
    logic          we;
    logic          we_ram;
    logic          we_gpio;
    logic          we_cycle;
    logic          we_tx;
    logic          we_status;
    logic [31:0]   cycle;
    logic [31:0]   status;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic [CW-1:0] fifo_count;
    logic          unused_addr;

    assign unused_addr = ^{Addr[31:11], Addr[1:0]};

    assign ram_idx   = Addr[AW+1:2];
    assign is_io     = Addr[10];
    assign io_sel    = Addr[3:2];
    assign we        = MemWrite & ~reset;
    assign we_ram    = we & ~is_io;
    assign we_gpio   = we & is_io & (io_sel == MMIO_GPIO);
    assign we_cycle  = we & is_io & (io_sel == MMIO_CYCLE);
    assign we_tx     = we & is_io & (io_sel == MMIO_TXDATA);
    assign we_status = we & is_io & (io_sel == MMIO_STATUS);
    assign TxValid   = ~fifo_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (we_tx),
        .push_data (WriteData[7:0]),
        .pop       (TxReady),
        .clr_ovf   (we_status & WriteData[ST_OVF]),
        .head      (TxData),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

    // RAM store path; contents survive reset
    always_ff @(posedge clk) begin
        if (we_ram) ram[ram_idx] <= WriteData;
    end

    // GPIO register and free-running, loadable cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            GpioOut <= '0;
            cycle   <= '0;
        end else begin
            if (we_gpio) GpioOut <= WriteData[7:0];
            cycle <= we_cycle ? WriteData : cycle + 32'd1;
        end
    end

    // STATUS word assembly
    always_comb begin
        status = '0;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_OVF]   = fifo_ovf;
        status[ST_CNT_LO +: ST_CNT_W] = ST_CNT_W'(fifo_count);
    end

    // Zero-latency read mux
    always_comb begin
        ReadData = ram[ram_idx];
        if (is_io) begin
            case (io_sel)
                MMIO_GPIO:   ReadData = {24'b0, GpioOut};
                MMIO_CYCLE:  ReadData = cycle;
                MMIO_TXDATA: ReadData = '0;
                default:     ReadData = status;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_dmem_mmio;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [7:0]  GpioOut;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    int n_cmp = 0;
    int n_err = 0;

    dmem_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .GpioOut   (GpioOut),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TxReady   (TxReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr      = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        Addr = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd(32'h404);
        n_cmp++;
        if (ReadData !== 32'h0) begin
            n_err++;
            $display("FAIL rst_cycle got %h exp %h", ReadData, 32'h0);
        end
        n_cmp++;
        if (GpioOut !== 8'h00 || TxValid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out got gpio=%h valid=%b exp 00/0", GpioOut, TxValid);
        end
        rd(32'h40C);
        n_cmp++;
        if (ReadData !== 32'h1) begin
            n_err++;
            $display("FAIL rst_status got %h exp %h", ReadData, 32'h1);
        end
        @(negedge clk);
    endtask

    task automatic test_ram;
        wr(32'h004, 32'hDEADBEEF);
        wr(32'h008, 32'h12345678);
        rd(32'h004);
        n_cmp++;
        if (ReadData !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL ram_rd got %h exp %h", ReadData, 32'hDEADBEEF);
        end
        rd(32'h804);
        n_cmp++;
        if (ReadData !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL ram_alias got %h exp %h", ReadData, 32'hDEADBEEF);
        end
        rd(32'hFFFF_F80B);
        n_cmp++;
        if (ReadData !== 32'h12345678) begin
            n_err++;
            $display("FAIL ram_alias2 got %h exp %h", ReadData, 32'h12345678);
        end
        rd(32'h408);
        n_cmp++;
        if (ReadData !== 32'h0) begin
            n_err++;
            $display("FAIL txdata_rd got %h exp %h", ReadData, 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_gpio;
        wr(32'h400, 32'h1A5);
        n_cmp++;
        if (GpioOut !== 8'hA5) begin
            n_err++;
            $display("FAIL gpio_out got %h exp %h", GpioOut, 8'hA5);
        end
        rd(32'h400);
        n_cmp++;
        if (ReadData !== 32'h000000A5) begin
            n_err++;
            $display("FAIL gpio_rd got %h exp %h", ReadData, 32'hA5);
        end
        @(negedge clk);
    endtask

    task automatic test_cycle;
        logic [31:0] exp_c [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
        wr(32'h404, 32'hFFFFFFFE);
        for (int i = 0; i < 3; i++) begin
            rd(32'h404);
            n_cmp++;
            if (ReadData !== exp_c[i]) begin
                n_err++;
                $display("FAIL cycle_%0d got %h exp %h", i, ReadData, exp_c[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fifo;
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        TxReady = 1'b0;
        wr(32'h408, 32'h11);
        wr(32'h408, 32'h22);
        wr(32'h408, 32'h33);
        wr(32'h408, 32'h44);
        wr(32'h408, 32'h55);
        rd(32'h40C);
        n_cmp++;
        if (ReadData !== 32'h46) begin
            n_err++;
            $display("FAIL fifo_ovf_status got %h exp %h", ReadData, 32'h46);
        end
        @(negedge clk);
        n_cmp++;
        if (TxValid !== 1'b1 || TxData !== 8'h11) begin
            n_err++;
            $display("FAIL fifo_hold got %b/%h exp 1/11", TxValid, TxData);
        end
        TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (TxValid !== 1'b1 || TxData !== exp_b[i]) begin
                n_err++;
                $display("FAIL fifo_drain_%0d got %b/%h exp 1/%h", i, TxValid, TxData, exp_b[i]);
            end
            @(negedge clk);
        end
        rd(32'h40C);
        n_cmp++;
        if (TxValid !== 1'b0 || ReadData !== 32'h05) begin
            n_err++;
            $display("FAIL fifo_empty got %b/%h exp 0/05", TxValid, ReadData);
        end
        TxReady = 1'b0;
        @(negedge clk);
        wr(32'h40C, 32'h4);
        rd(32'h40C);
        n_cmp++;
        if (ReadData !== 32'h01) begin
            n_err++;
            $display("FAIL ovf_clear got %h exp %h", ReadData, 32'h01);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_b [4] = '{8'h02, 8'h03, 8'h04, 8'h66};
        TxReady = 1'b0;
        wr(32'h408, 32'h01);
        wr(32'h408, 32'h02);
        wr(32'h408, 32'h03);
        wr(32'h408, 32'h04);
        TxReady = 1'b1;
        wr(32'h408, 32'h66);
        TxReady = 1'b0;
        rd(32'h40C);
        n_cmp++;
        if (ReadData !== 32'h42 || TxData !== 8'h02) begin
            n_err++;
            $display("FAIL full_pushpop got %h/%h exp 42/02", ReadData, TxData);
        end
        @(negedge clk);
        TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (TxValid !== 1'b1 || TxData !== exp_b[i]) begin
                n_err++;
                $display("FAIL pp_drain_%0d got %b/%h exp 1/%h", i, TxValid, TxData, exp_b[i]);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (TxValid !== 1'b0) begin
            n_err++;
            $display("FAIL pp_empty got %b exp 0", TxValid);
        end
        TxReady = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        TxReady = 1'b0;
        wr(32'h408, 32'h77);
        wr(32'h408, 32'h88);
        wr(32'h400, 32'hA5);
        rd(32'h40C);
        n_cmp++;
        if (ReadData !== 32'h20 || GpioOut !== 8'hA5) begin
            n_err++;
            $display("FAIL pre_rst got %h/%h exp 20/a5", ReadData, GpioOut);
        end
        @(negedge clk);
        reset     = 1'b1;
        Addr      = 32'h004;
        WriteData = 32'h12345678;
        MemWrite  = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        rd(32'h40C);
        n_cmp++;
        if (ReadData !== 32'h01 || TxValid !== 1'b0 || GpioOut !== 8'h00) begin
            n_err++;
            $display("FAIL mid_rst got st=%h v=%b g=%h exp 01/0/00", ReadData, TxValid, GpioOut);
        end
        rd(32'h404);
        n_cmp++;
        if (ReadData !== 32'h0) begin
            n_err++;
            $display("FAIL mid_rst_cycle got %h exp %h", ReadData, 32'h0);
        end
        rd(32'h004);
        n_cmp++;
        if (ReadData !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL mid_rst_ram got %h exp %h", ReadData, 32'hDEADBEEF);
        end
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        Addr      = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        TxReady   = 1'b0;
        @(negedge clk);
        test_reset();
        test_ram();
        test_gpio();
        test_cycle();
        test_fifo();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
